// File: rtl/serv_dbus_ctrl.sv
// Data-bus controller for a bit-serial core: gathers store data serially, runs one
// Wishbone-style bus cycle per request, and streams the (extended) load result back out.
module serv_dbus_ctrl #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int LB             = $clog2(BITS_PER_CYCLE)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mem_req,
    input  logic                      i_we,
    input  logic [1:0]                i_size,
    input  logic                      i_signed,
    input  logic [1:0]                i_lsb,
    input  logic [31:0]               i_adr,
    input  logic                      i_st_en,
    input  logic [BITS_PER_CYCLE-1:0] i_rs2,
    input  logic                      i_en,
    output logic [BITS_PER_CYCLE-1:0] o_rd,
    output logic [31:0]               o_dbus_adr,
    output logic [31:0]               o_dbus_dat,
    output logic [3:0]                o_dbus_sel,
    output logic                      o_dbus_we,
    output logic                      o_dbus_cyc,
    input  logic [31:0]               i_dbus_rdt,
    input  logic                      i_dbus_ack,
    output logic                      o_ack,
    output logic                      o_misalign,
    output logic                      o_busy,
    output logic [1:0]                o_state
);

    // Handshake: a request is taken only in IDLE on a cycle with i_mem_req high;
    // o_dbus_cyc then stays high with all bus fields frozen until i_dbus_ack is
    // sampled high, which ends the cycle on that edge (single-beat, no timeout).

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        READOUT = 2'd2
    } state_t;

    localparam logic [4:0] STEP = 5'(1 << LB);
    localparam logic [4:0] LAST = 5'(32 - (1 << LB));

    state_t      state_q, state_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        ack_q, ack_d;
    logic        mis_q, mis_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lsb_q, lsb_d;

    logic        misaligned;
    logic [3:0]  sel_req;
    logic [31:0] dat_req;
    logic [31:0] ext;

    always_comb begin
        misaligned = ((i_size == 2'b01) && i_lsb[0]) || (i_size[1] && (i_lsb != 2'b00));
        case (i_size)
            2'b00:   sel_req = 4'b0001 << i_lsb;
            2'b01:   sel_req = i_lsb[1] ? 4'b1100 : 4'b0011;
            default: sel_req = 4'b1111;
        endcase
        case (i_size)
            2'b00:   dat_req = {4{wdata_q[7:0]}};
            2'b01:   dat_req = {2{wdata_q[15:0]}};
            default: dat_req = wdata_q;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   ext = {{24{signed_q & rdata_q[7]}}, rdata_q[7:0]};
            2'b01:   ext = {{16{signed_q & rdata_q[15]}}, rdata_q[15:0]};
            default: ext = rdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        size_d   = size_q;
        signed_d = signed_q;
        lsb_d    = lsb_q;
        ack_d    = 1'b0;
        mis_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_st_en) begin
                    wdata_d = {i_rs2, wdata_q[31:BITS_PER_CYCLE]};
                end
                if (i_mem_req) begin
                    if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d  = BUS;
                        cyc_d    = 1'b1;
                        adr_d    = i_adr;
                        we_d     = i_we;
                        sel_d    = sel_req;
                        dat_d    = dat_req;
                        size_d   = i_size;
                        signed_d = i_signed;
                        lsb_d    = i_lsb;
                    end
                end
            end
            BUS: begin
                if (i_dbus_ack) begin
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = we_q ? IDLE : READOUT;
                    // Align the addressed byte/half down to bit 0 before extension.
                    rdata_d = i_dbus_rdt >> {lsb_q, 3'b000};
                    cnt_d   = 5'd0;
                end
            end
            READOUT: begin
                if (i_en) begin
                    cnt_d = cnt_q + STEP;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            ack_q    <= 1'b0;
            mis_q    <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            lsb_q    <= '0;
        end else begin
            state_q  <= state_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            ack_q    <= ack_d;
            mis_q    <= mis_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lsb_q    <= lsb_d;
        end
    end

    assign o_rd       = ((state_q == READOUT) && i_en) ? ext[cnt_q +: BITS_PER_CYCLE] : '0;
    assign o_dbus_adr = adr_q;
    assign o_dbus_dat = dat_q;
    assign o_dbus_sel = sel_q;
    assign o_dbus_we  = we_q;
    assign o_dbus_cyc = cyc_q;
    assign o_ack      = ack_q;
    assign o_misalign = mis_q;
    assign o_busy     = (state_q != IDLE);
    assign o_state    = state_q;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Bench for serv_dbus_ctrl: a 1-bit instance for most traffic and a 4-bit instance
// for the nibble-serial half-word load.
module tb_serv_dbus_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 1-bit instance
    logic        mem_req1 = 0, we1 = 0, sgn1 = 0, st_en1 = 0, en1 = 0, dbus_ack1 = 0;
    logic [1:0]  size1 = 0, lsb1 = 0;
    logic [31:0] adr1 = 0, dbus_rdt1 = 0;
    logic [0:0]  rs2_1 = 0, rd1;
    logic [31:0] dadr1, ddat1;
    logic [3:0]  dsel1;
    logic        dwe1, cyc1, ack1, mis1, busy1;
    logic [1:0]  state1;

    // 4-bit instance
    logic        mem_req4 = 0, we4 = 0, sgn4 = 0, st_en4 = 0, en4 = 0, dbus_ack4 = 0;
    logic [1:0]  size4 = 0, lsb4 = 0;
    logic [31:0] adr4 = 0, dbus_rdt4 = 0;
    logic [3:0]  rs2_4 = 0, rd4;
    logic [31:0] dadr4, ddat4;
    logic [3:0]  dsel4;
    logic        dwe4, cyc4, ack4, mis4, busy4;
    logic [1:0]  state4;

    serv_dbus_ctrl #(.BITS_PER_CYCLE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_mem_req(mem_req1), .i_we(we1), .i_size(size1),
        .i_signed(sgn1), .i_lsb(lsb1), .i_adr(adr1), .i_st_en(st_en1), .i_rs2(rs2_1),
        .i_en(en1), .o_rd(rd1), .o_dbus_adr(dadr1), .o_dbus_dat(ddat1), .o_dbus_sel(dsel1),
        .o_dbus_we(dwe1), .o_dbus_cyc(cyc1), .i_dbus_rdt(dbus_rdt1), .i_dbus_ack(dbus_ack1),
        .o_ack(ack1), .o_misalign(mis1), .o_busy(busy1), .o_state(state1)
    );

    serv_dbus_ctrl #(.BITS_PER_CYCLE(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_mem_req(mem_req4), .i_we(we4), .i_size(size4),
        .i_signed(sgn4), .i_lsb(lsb4), .i_adr(adr4), .i_st_en(st_en4), .i_rs2(rs2_4),
        .i_en(en4), .o_rd(rd4), .o_dbus_adr(dadr4), .o_dbus_dat(ddat4), .o_dbus_sel(dsel4),
        .o_dbus_we(dwe4), .o_dbus_cyc(cyc4), .i_dbus_rdt(dbus_rdt4), .i_dbus_ack(dbus_ack4),
        .o_ack(ack4), .o_misalign(mis4), .o_busy(busy4), .o_state(state4)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected queues: bus request {adr,dat,sel,we}; {cyc,busy} at o_ack / o_misalign; load words
    logic [68:0] exp_bus_q[$];
    logic [1:0]  exp_ack_q[$];
    logic [1:0]  exp_mis_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_rd4_q[$];

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none @%0t", name, $time);
    endtask

    // monitor / scoreboard
    logic        cyc1_prev = 0;
    logic [68:0] bus_snap = 0;
    logic [31:0] acc1 = 0, acc4 = 0;
    int          bitpos1 = 0, bitpos4 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cyc1 && !cyc1_prev) begin
                bus_snap = {dadr1, ddat1, dsel1, dwe1};
                if (exp_bus_q.size() == 0) unexpected("bus_start");
                else check("bus_req", bus_snap, exp_bus_q.pop_front());
            end else if (cyc1) begin
                check("bus_stable", {dadr1, ddat1, dsel1, dwe1}, bus_snap);
            end
            if (ack1) begin
                if (exp_ack_q.size() == 0) unexpected("ack");
                else check("ack_cyc_busy", {cyc1, busy1}, exp_ack_q.pop_front());
            end
            if (mis1) begin
                if (exp_mis_q.size() == 0) unexpected("misalign");
                else check("mis_busy_cyc", {busy1, cyc1}, exp_mis_q.pop_front());
            end
            if (state1 == 2'd2) begin
                if (en1) begin
                    acc1[bitpos1] = rd1[0];
                    bitpos1++;
                    if (bitpos1 == 32) begin
                        bitpos1 = 0;
                        if (exp_rd_q.size() == 0) unexpected("load1");
                        else check("load1_word", acc1, exp_rd_q.pop_front());
                    end
                end else begin
                    check("rd1_idle_zero", rd1, 0);
                end
            end
            if (state4 == 2'd2 && en4) begin
                acc4[bitpos4 +: 4] = rd4;
                bitpos4 += 4;
                if (bitpos4 == 32) begin
                    bitpos4 = 0;
                    if (exp_rd4_q.size() == 0) unexpected("load4");
                    else check("load4_word", acc4, exp_rd4_q.pop_front());
                end
            end
        end
        cyc1_prev = cyc1;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word1(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            st_en1 = 1;
            rs2_1  = v[i];
            tick();
        end
        st_en1 = 0;
        rs2_1  = 0;
    endtask

    task automatic req1(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [1:0] lsb, input logic [31:0] adr, input logic st);
        mem_req1 = 1; we1 = we; size1 = size; sgn1 = sgn; lsb1 = lsb; adr1 = adr;
        st_en1 = st; rs2_1 = st;
        tick();
        mem_req1 = 0; st_en1 = 0; rs2_1 = 0;
    endtask

    task automatic ack1_after(input int n, input logic [31:0] rdt);
        repeat (n) tick();
        dbus_rdt1 = rdt;
        dbus_ack1 = 1;
        tick();
        dbus_ack1 = 0;
    endtask

    task automatic readout1(input int gap_at, input logic req_at_end);
        for (int i = 0; i < 32; i++) begin
            if (i == gap_at) begin
                en1 = 0;
                tick();
            end
            en1 = 1;
            if (req_at_end && i == 31) begin
                mem_req1 = 1; we1 = 0; size1 = 2'b10; lsb1 = 0; adr1 = 32'h700;
            end
            tick();
        end
        en1 = 0;
        mem_req1 = 0;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_cyc", cyc1, 0);
        check("rst_bus_fields", {dadr1, ddat1, dsel1, dwe1}, 0);
        check("rst_ack_mis_busy", {ack1, mis1, busy1}, 0);
        check("rst_rd", rd1, 0);
        rst = 0;
        tick();

        // word store 0xDEADBEEF
        shift_word1(32'hDEADBEEF);
        exp_bus_q.push_back({32'h100, 32'hDEADBEEF, 4'b1111, 1'b1});
        exp_ack_q.push_back(2'b00);
        req1(1, 2'b10, 0, 2'd0, 32'h100, 0);
        check("store_busy", busy1, 1);
        ack1_after(3, 32'h0);
        tick();
        check("store_idle", busy1, 0);

        // signed byte load, lsb 3; a request on the final readout cycle must be dropped
        exp_bus_q.push_back({32'h200, 32'hEFEFEFEF, 4'b1000, 1'b0});
        exp_ack_q.push_back(2'b01);
        exp_rd_q.push_back(32'hFFFFFF80);
        req1(0, 2'b00, 1, 2'd3, 32'h200, 0);
        ack1_after(2, 32'h80FFFFFF);
        readout1(8, 1);
        check("wrap_idle", busy1, 0);
        tick();
        check("wrap_req_ignored", cyc1, 0);

        // unsigned repeat
        exp_bus_q.push_back({32'h200, 32'hEFEFEFEF, 4'b1000, 1'b0});
        exp_ack_q.push_back(2'b01);
        exp_rd_q.push_back(32'h00000080);
        req1(0, 2'b00, 0, 2'd3, 32'h200, 0);
        ack1_after(1, 32'h80FFFFFF);
        readout1(-1, 0);

        // misaligned word and half
        exp_mis_q.push_back(2'b00);
        req1(0, 2'b10, 0, 2'd1, 32'h204, 0);
        for (int i = 0; i < 3; i++) check("mis_word_quiet", {busy1, cyc1}, 0);
        exp_mis_q.push_back(2'b00);
        req1(1, 2'b01, 0, 2'd3, 32'h208, 0);
        repeat (2) tick();
        check("mis_half_quiet", {busy1, cyc1}, 0);

        // byte store lsb 2; requests and shift strobes during BUS are ignored
        shift_word1(32'h123456A5);
        exp_bus_q.push_back({32'h300, 32'hA5A5A5A5, 4'b0100, 1'b1});
        exp_ack_q.push_back(2'b00);
        req1(1, 2'b00, 0, 2'd2, 32'h300, 0);
        mem_req1 = 1; we1 = 0; size1 = 2'b10; lsb1 = 0; adr1 = 32'h999;
        st_en1 = 1; rs2_1 = 1;
        repeat (2) tick();
        mem_req1 = 0; st_en1 = 0; rs2_1 = 0;
        ack1_after(2, 32'h0);

        // half store lsb 2 with a coincident shift strobe: bus gets pre-shift data
        exp_bus_q.push_back({32'h304, 32'h56A556A5, 4'b1100, 1'b1});
        exp_ack_q.push_back(2'b00);
        req1(1, 2'b01, 0, 2'd2, 32'h304, 1);
        ack1_after(1, 32'h0);

        // word store shows the post-shift data
        exp_bus_q.push_back({32'h308, 32'h891A2B52, 4'b1111, 1'b1});
        exp_ack_q.push_back(2'b00);
        req1(1, 2'b11, 0, 2'd0, 32'h308, 0);
        ack1_after(0, 32'h0);

        // word load with an i_en gap
        exp_bus_q.push_back({32'h30C, 32'h891A2B52, 4'b1111, 1'b0});
        exp_ack_q.push_back(2'b01);
        exp_rd_q.push_back(32'hCAFEF00D);
        req1(0, 2'b10, 1, 2'd0, 32'h30C, 0);
        ack1_after(1, 32'hCAFEF00D);
        readout1(10, 0);
        tick();

        // reset two cycles into BUS with a concurrent ack
        exp_bus_q.push_back({32'h500, 32'h891A2B52, 4'b1111, 1'b0});
        req1(0, 2'b10, 0, 2'd0, 32'h500, 0);
        tick();
        dbus_rdt1 = 32'h12345678;
        dbus_ack1 = 1;
        rst = 1;
        #1;
        check("rst_mid_bus_cyc", cyc1, 0);
        check("rst_mid_bus_busy", busy1, 0);
        check("rst_mid_bus_fields", {dadr1, ddat1, dsel1, dwe1}, 0);
        tick();
        dbus_ack1 = 0;
        tick();
        rst = 0;
        exp_bus_q.push_back({32'h600, 32'h0, 4'b1111, 1'b1});
        exp_ack_q.push_back(2'b00);
        req1(1, 2'b10, 0, 2'd0, 32'h600, 0);
        check("post_rst_accept", cyc1, 1);
        ack1_after(1, 32'h0);

        // 4-bit instance: signed half load, lsb 2
        mem_req4 = 1; we4 = 0; size4 = 2'b01; sgn4 = 1; lsb4 = 2'd2; adr4 = 32'h400;
        tick();
        mem_req4 = 0;
        check("h4_bus", {dadr4, ddat4, dsel4, dwe4}, {32'h400, 32'h0, 4'b1100, 1'b0});
        check("h4_cyc_busy", {cyc4, busy4}, 2'b11);
        repeat (2) tick();
        dbus_rdt4 = 32'h7FFF1234;
        dbus_ack4 = 1;
        exp_rd4_q.push_back(32'h00007FFF);
        tick();
        dbus_ack4 = 0;
        check("h4_ack", {ack4, cyc4, busy4}, 3'b101);
        for (int i = 0; i < 8; i++) begin
            en4 = 1;
            tick();
        end
        en4 = 0;
        check("h4_idle", busy4, 0);

        repeat (3) tick();
        check("left_bus", exp_bus_q.size(), 0);
        check("left_ack", exp_ack_q.size(), 0);
        check("left_mis", exp_mis_q.size(), 0);
        check("left_rd1", exp_rd_q.size(), 0);
        check("left_rd4", exp_rd4_q.size(), 0);
        check("partial_rd", {bitpos1[7:0], bitpos4[7:0]}, 0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
